// File: rtl/pe_result_collector.sv
// Show-ahead result FIFO behind the last PE; tags each word with its frame-end flag.
// Entries are {tag, result, last}; overflow stays set until clrIn.
module pe_result_collector #(
   parameter int DATA_WIDTH = 8,
   parameter int BLOCK_LEN  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_WIDTH-1:0]       zIn,
   input  logic                        loadIn,
   input  logic                        sumDiffSelIn,
   input  logic                        clrIn,
   output logic [DATA_WIDTH:0]         mData,
   output logic                        mValid,
   input  logic                        mReady,
   output logic                        mLast,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        overflow
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(BLOCK_LEN);
   localparam int EW = DATA_WIDTH + 2;
   localparam logic [CW-1:0] FC_LAST = CW'(BLOCK_LEN - 1);
   localparam logic [LW-1:0] LV_FULL = LW'(FIFO_DEPTH);

   logic [EW-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic [CW-1:0] r_fcnt;
   logic          r_ovf;

   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic          w_last;
   logic [EW-1:0] w_head;

   assign w_full = (r_level == LV_FULL);
   assign mValid = (r_level != '0);
   assign w_pop  = mValid & mReady;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign w_push = loadIn & (~w_full | w_pop);
   assign w_drop = loadIn & w_full & ~w_pop;
   assign w_last = (r_fcnt == FC_LAST);
   assign w_head = r_mem[r_rptr];

   assign mData    = mValid ? w_head[EW-1:1] : '0;
   assign mLast    = mValid & w_head[0];
   assign level    = r_level;
   assign overflow = r_ovf;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {sumDiffSelIn, zIn, w_last};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_fcnt  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         // Dropped captures still advance the frame position.
         if (clrIn) begin
            r_fcnt <= '0;
         end else if (loadIn) begin
            r_fcnt <= w_last ? '0 : r_fcnt + 1'b1;
         end
         if (clrIn) begin
            r_ovf <= 1'b0;
         end else if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pe_result_collector.sv
// Bench for pe_result_collector: queue model checked every cycle,
// directed frame/overflow/clear/reset cases and a random stall run.
module tb_pe_result_collector;
   localparam int DW = 8;
   localparam int BL = 8;
   localparam int FD = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] zIn = '0;
   logic          loadIn = 1'b0;
   logic          sumDiffSelIn = 1'b0;
   logic          clrIn = 1'b0;
   logic          mReady = 1'b0;
   logic [DW:0]   mData;
   logic          mValid;
   logic          mLast;
   logic [$clog2(FD):0] level;
   logic          overflow;

   int checks = 0;
   int passed = 0;

   logic [DW+1:0] mq[$];
   logic [DW+1:0] expq[$];
   logic [DW+1:0] outq[$];
   int fcnt = 0;
   bit movf = 1'b0;

   pe_result_collector #(
      .DATA_WIDTH(DW),
      .BLOCK_LEN (BL),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .zIn         (zIn),
      .loadIn      (loadIn),
      .sumDiffSelIn(sumDiffSelIn),
      .clrIn       (clrIn),
      .mData       (mData),
      .mValid      (mValid),
      .mReady      (mReady),
      .mLast       (mLast),
      .level       (level),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // Reference: a queue of {tag, data, last} plus frame position and flag.
   always @(posedge clk or negedge rst_n) begin
      bit pop;
      bit acc;
      logic [DW+1:0] e;
      if (!rst_n) begin
         mq.delete();
         fcnt = 0;
         movf = 1'b0;
      end else begin
         pop = (mq.size() != 0) && mReady;
         acc = 1'b0;
         e = {sumDiffSelIn, zIn, 1'(fcnt == BL - 1)};
         if (loadIn) begin
            if (mq.size() < FD || pop) acc = 1'b1;
            else movf = 1'b1;
            fcnt = (fcnt + 1) % BL;
         end
         if (clrIn) begin
            fcnt = 0;
            movf = 1'b0;
         end
         if (pop) void'(mq.pop_front());
         if (acc) begin
            mq.push_back(e);
            expq.push_back(e);
         end
      end
   end

   logic [DW:0] pd;
   logic        pl;
   bit          pstall = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("mValid", mValid, mq.size() != 0);
         chk("level", level, mq.size());
         chk("overflow", overflow, movf);
         if (mq.size() != 0) begin
            chk("mData", mData, mq[0][DW+1:1]);
            chk("mLast", mLast, mq[0][0]);
         end
         if (pstall) begin
            chk("stall_data", mData, pd);
            chk("stall_last", mLast, pl);
         end
         if (mValid && mReady) outq.push_back({mData, mLast});
         pstall = mValid && !mReady;
         pd = mData;
         pl = mLast;
      end else begin
         pstall = 1'b0;
      end
   end

   task automatic push(input logic [DW-1:0] d, input logic t);
      zIn = d;
      sumDiffSelIn = t;
      loadIn = 1'b1;
      @(posedge clk);
      #1 loadIn = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_pulse();
      clrIn = 1'b1;
      @(posedge clk);
      #1 clrIn = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int pushes;
      int cyc;
      #12;
      chk("rst_mValid", mValid, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_mData", mData, 0);
      chk("rst_mLast", mLast, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // One full frame streaming straight through.
      mReady = 1'b1;
      outq.delete();
      for (int i = 0; i < 8; i++) push(DW'(i), 1'(i % 2));
      idle(3);
      chk("s1_count", outq.size(), 8);
      for (int i = 0; i < 8 && i < outq.size(); i++)
         chk($sformatf("s1_word%0d", i), outq[i],
             {1'(i % 2), DW'(i), 1'(i == 7)});
      chk("s1_overflow", overflow, 0);

      // Fill past full with the sink stalled.
      mReady = 1'b0;
      outq.delete();
      for (int i = 0; i < 17; i++) push(DW'(i), 1'(i % 2));
      chk("s2_level", level, 16);
      chk("s2_overflow", overflow, 1);
      clr_pulse();
      chk("s2_clr_overflow", overflow, 0);

      // Push and pop together while full.
      zIn = 8'hAA;
      sumDiffSelIn = 1'b1;
      loadIn = 1'b1;
      mReady = 1'b1;
      @(posedge clk);
      #1 loadIn = 1'b0;
      mReady = 1'b0;
      chk("s3_level", level, 16);
      chk("s3_overflow", overflow, 0);
      mReady = 1'b1;
      idle(20);
      chk("s3_count", outq.size(), 17);
      for (int i = 0; i < 16 && i < outq.size(); i++)
         chk($sformatf("s2_word%0d", i), outq[i],
             {1'(i % 2), DW'(i), 1'(i == 7 || i == 15)});
      if (outq.size() == 17)
         chk("s3_tail", outq[16], {1'b1, 8'hAA, 1'b0});

      // Clear mid-frame restarts frame position.
      outq.delete();
      for (int i = 0; i < 3; i++) push(DW'(8'h20 + i), 1'b0);
      clr_pulse();
      for (int i = 0; i < 8; i++) push(DW'(8'h30 + i), 1'b1);
      idle(4);
      chk("s4_count", outq.size(), 11);
      for (int i = 0; i < 11 && i < outq.size(); i++)
         chk($sformatf("s4_word%0d", i), outq[i],
             (i < 3) ? {1'b0, DW'(8'h20 + i), 1'b0}
                     : {1'b1, DW'(8'h30 + i - 3), 1'(i == 10)});

      // Asynchronous reset with data buffered mid-frame.
      mReady = 1'b0;
      for (int i = 0; i < 5; i++) push(DW'(8'h50 + i), 1'b0);
      chk("s5_pre_level", level, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("s5_mValid", mValid, 0);
      chk("s5_level", level, 0);
      chk("s5_mData", mData, 0);
      chk("s5_mLast", mLast, 0);
      idle(2);
      rst_n = 1'b1;
      outq.delete();
      mReady = 1'b1;
      for (int i = 0; i < 8; i++) push(DW'(8'h3C + i), 1'b0);
      idle(3);
      chk("s5_count", outq.size(), 8);
      for (int i = 0; i < 8 && i < outq.size(); i++)
         chk($sformatf("s5_word%0d", i), outq[i],
             {1'b0, DW'(8'h3C + i), 1'(i == 7)});

      // Random traffic with random backpressure.
      outq.delete();
      expq.delete();
      pushes = 0;
      cyc = 0;
      while (pushes < 100 && cyc < 3000) begin
         loadIn = ($urandom_range(0, 9) < 6);
         zIn = DW'($urandom);
         sumDiffSelIn = 1'($urandom);
         mReady = 1'($urandom_range(0, 1));
         clrIn = ($urandom_range(0, 29) == 0);
         @(posedge clk);
         #1;
         if (loadIn) pushes++;
         cyc++;
      end
      loadIn = 1'b0;
      clrIn = 1'b0;
      mReady = 1'b1;
      idle(FD + 4);
      chk("s6_pushes", pushes, 100);
      chk("s6_drained", level, 0);
      chk("s6_count", outq.size(), expq.size());
      for (int i = 0; i < outq.size() && i < expq.size(); i++)
         chk($sformatf("s6_word%0d", i), outq[i], expq[i]);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
